pmem_wb_bridge: RTL and testbench

Registered Wishbone master stage directly downstream of the program/data memory mux's SRAM port.
- Takes the mux's single-cycle-level request (cyc/stb/we/sel/10-bit byte address/replicated data) and runs one Wishbone classic cycle per request on the shared OpenRAM bus.
- Returns read data and a one-cycle ack back to the mux.
- Adds address relocation, a bus timeout, and sticky error reporting so a hung or erroring slave cannot stall the CPU.

---
 rtl/pmem_pkg.sv | 24 ++
 rtl/pmem_wb_timeout.sv | 43 ++++
 rtl/pmem_wb_bridge.sv | 146 ++++++++++++++
 tb/tb_pmem_wb_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// ----------------------------------------------------------------------------
// pmem_pkg
// Shared definitions for the program/data memory Wishbone bridge:
//   - bridge state encoding
//   - default relocation base and error read-data
//   - bus width constants and the timeout counter width
// ----------------------------------------------------------------------------
package pmem_pkg;

    localparam int unsigned PMEM_ADDR_W = 10;
    localparam int unsigned WB_DAT_W    = 32;
    localparam int unsigned TMO_CNT_W   = 16;

    localparam logic [WB_DAT_W-1:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [WB_DAT_W-1:0] DEF_ERR_DATA  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } pmem_state_t;

endpackage

// File: rtl/pmem_wb_timeout.sv
// ----------------------------------------------------------------------------
// pmem_wb_timeout
// Bus-cycle watchdog for Wishbone masters.
//   i_clock    : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_clear    : restart the count from zero (wins over i_en)
//   i_en       : count one cycle
//   o_expired  : high during the cycle whose closing edge completes
//                TIMEOUT counted cycles, so a master acting on it holds
//                the bus for exactly TIMEOUT cycles
// ----------------------------------------------------------------------------
module pmem_wb_timeout
    import pmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMO_CNT_W-1:0] LP_LAST = TMO_CNT_W'(TIMEOUT - 1);

    logic [TMO_CNT_W-1:0] r_cnt;
    logic                 w_at_last;

    assign w_at_last = (r_cnt == LP_LAST);
    assign o_expired = i_en && w_at_last;

    // Saturates at the last value so a user that keeps counting never wraps.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_last) begin
            r_cnt <= r_cnt + TMO_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pmem_wb_bridge.sv
// ----------------------------------------------------------------------------
// pmem_wb_bridge
// Registered Wishbone classic master behind the memory mux SRAM port.
// One bus cycle per mux request, relocated by BASE_ADDR, with a watchdog
// and sticky error flags so a dead slave cannot stall the CPU.
//   clock, reset              : clock / async active-low reset
//   req_cyc/stb/we/sel/addr/dat : request from mux
//   req_dat_o, req_ack        : registered read data, one-cycle completion
//   wb_*_o / wb_*_i           : Wishbone master interface
//   err_clear                 : clears sticky flags (a same-cycle set wins)
//   err_timeout, err_bus      : sticky timeout / bus-error flags
// ----------------------------------------------------------------------------
module pmem_wb_bridge
    import pmem_pkg::*;
#(
    parameter logic [WB_DAT_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned         TIMEOUT   = 255,
    parameter logic [WB_DAT_W-1:0] ERR_DATA  = DEF_ERR_DATA
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_cyc,
    input  logic                   req_stb,
    input  logic                   req_we,
    input  logic [3:0]             req_sel,
    input  logic [PMEM_ADDR_W-1:0] req_addr,
    input  logic [WB_DAT_W-1:0]    req_dat,
    output logic [WB_DAT_W-1:0]    req_dat_o,
    output logic                   req_ack,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o,
    output logic [WB_DAT_W-1:0]    wb_adr_o,
    output logic [WB_DAT_W-1:0]    wb_dat_o,
    input  logic [WB_DAT_W-1:0]    wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   err_clear,
    output logic                   err_timeout,
    output logic                   err_bus
);

    pmem_state_t           r_state;
    logic [WB_DAT_W-1:0]   r_req_dat;
    logic                  r_req_ack;
    logic                  r_bus_act;   // drives both wb_cyc_o and wb_stb_o
    logic                  r_wb_we;
    logic [3:0]            r_wb_sel;
    logic [WB_DAT_W-1:0]   r_wb_adr;
    logic [WB_DAT_W-1:0]   r_wb_dat;
    logic                  r_err_timeout;
    logic                  r_err_bus;

    logic                  w_tmo_clear;
    logic                  w_tmo_en;
    logic                  w_tmo_expired;

    assign w_tmo_clear = (r_state == ST_IDLE);
    assign w_tmo_en    = (r_state == ST_BUS);

    pmem_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_clear   (w_tmo_clear),
        .i_en      (w_tmo_en),
        .o_expired (w_tmo_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_req_dat     <= '0;
            r_req_ack     <= 1'b0;
            r_bus_act     <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_sel      <= '0;
            r_wb_adr      <= '0;
            r_wb_dat      <= '0;
            r_err_timeout <= 1'b0;
            r_err_bus     <= 1'b0;
        end else begin
            r_req_ack <= 1'b0;
            // Clear first; any set below in the same cycle overrides it.
            if (err_clear) begin
                r_err_timeout <= 1'b0;
                r_err_bus     <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_cyc && req_stb) begin
                        r_wb_we   <= req_we;
                        r_wb_sel  <= req_sel;
                        r_wb_dat  <= req_dat;
                        r_wb_adr  <= BASE_ADDR + {{(WB_DAT_W-PMEM_ADDR_W){1'b0}}, req_addr};
                        r_bus_act <= 1'b1;
                        r_state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Abort outranks any response arriving in the same cycle.
                    if (!req_stb) begin
                        r_bus_act <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        if (!r_wb_we) r_req_dat <= wb_dat_i;
                        r_bus_act <= 1'b0;
                        r_req_ack <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (wb_err_i || w_tmo_expired) begin
                        if (!r_wb_we) r_req_dat <= ERR_DATA;
                        if (wb_err_i) r_err_bus     <= 1'b1;
                        else          r_err_timeout <= 1'b1;
                        r_bus_act <= 1'b0;
                        r_req_ack <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // The mux keeps strobing until it sees data; wait it out.
                    if (!req_stb) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_dat_o   = r_req_dat;
    assign req_ack     = r_req_ack;
    assign wb_cyc_o    = r_bus_act;
    assign wb_stb_o    = r_bus_act;
    assign wb_we_o     = r_wb_we;
    assign wb_sel_o    = r_wb_sel;
    assign wb_adr_o    = r_wb_adr;
    assign wb_dat_o    = r_wb_dat;
    assign err_timeout = r_err_timeout;
    assign err_bus     = r_err_bus;

endmodule

// File: tb/tb_pmem_wb_bridge.sv
// ----------------------------------------------------------------------------
// tb_pmem_wb_bridge
// Self-checking bench for pmem_wb_bridge (TIMEOUT overridden to 4).
// Each request is driven as a mux would, the slave side is played per
// cycle, and results are compared with a transaction-level model.
// ----------------------------------------------------------------------------
module tb_pmem_wb_bridge;

    localparam int unsigned TO   = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_BOTH   = 2;
    localparam int K_SILENT = 3;
    localparam int K_ABORT  = 4;

    logic        clock;
    logic        reset;
    logic        req_cyc, req_stb, req_we;
    logic [3:0]  req_sel;
    logic [9:0]  req_addr;
    logic [31:0] req_dat;
    logic [31:0] req_dat_o;
    logic        req_ack;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic        err_clear, err_timeout, err_bus;

    pmem_wb_bridge #(
        .TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_cyc     (req_cyc),
        .req_stb     (req_stb),
        .req_we      (req_we),
        .req_sel     (req_sel),
        .req_addr    (req_addr),
        .req_dat     (req_dat),
        .req_dat_o   (req_dat_o),
        .req_ack     (req_ack),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .err_clear   (err_clear),
        .err_timeout (err_timeout),
        .err_bus     (err_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference state: last read data delivered and sticky flags.
    logic [31:0] m_dat;
    logic        m_to;
    logic        m_bus;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_cyc   = 1'b0;
        req_stb   = 1'b0;
        req_we    = 1'b0;
        req_sel   = '0;
        req_addr  = '0;
        req_dat   = '0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        m_to  = 1'b0;
        m_bus = 1'b0;
        check_val("clr_to", 32'(err_timeout), 32'(m_to));
        check_val("clr_bus", 32'(err_bus), 32'(m_bus));
    endtask

    // kind: slave behaviour; wait_n: stb cycles before the response (or
    // abort) lands on stb cycle wait_n+1; hold_n: cycles the mux keeps
    // strobing after it sees req_ack.
    task automatic run_txn(input bit we, input logic [3:0] sel, input logic [9:0] addr,
                           input logic [31:0] dat, input int kind, input int wait_n,
                           input int hold_n, input logic [31:0] sdat, input bit rand_clr);
        int stb_cyc    = 0;
        int bus_starts = 0;
        int acks       = 0;
        int ack_at     = -1;
        int last_stb   = -1;
        int rel_cnt    = 0;
        int exp_stb;
        bit prev_stb   = 1'b0;
        bit released   = 1'b0;
        bit clr;

        exp_stb = (kind == K_SILENT) ? int'(TO) : wait_n + 1;

        @(negedge clock);
        req_cyc  = 1'b1;
        req_stb  = 1'b1;
        req_we   = we;
        req_sel  = sel;
        req_addr = addr;
        req_dat  = dat;

        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clock);
            if (wb_stb_o && !prev_stb) begin
                bus_starts++;
                if (bus_starts == 1) begin
                    check_val("wb_adr", wb_adr_o, BASE + {22'd0, addr});
                    check_val("wb_we", 32'(wb_we_o), 32'(we));
                    check_val("wb_sel", 32'(wb_sel_o), 32'(sel));
                    check_val("wb_dat", wb_dat_o, dat);
                    check_val("wb_cyc", 32'(wb_cyc_o), 32'd1);
                end
            end
            if (wb_stb_o) begin
                stb_cyc++;
                last_stb = cyc;
            end
            prev_stb = wb_stb_o;
            if (req_ack) begin
                acks++;
                ack_at = cyc;
            end

            wb_ack_i  = 1'b0;
            wb_err_i  = 1'b0;
            wb_dat_i  = $urandom;
            clr       = rand_clr && ($urandom_range(0, 7) == 0);
            err_clear = clr;
            if (clr) begin
                m_to  = 1'b0;
                m_bus = 1'b0;
            end

            if (wb_stb_o && !released) begin
                if (kind == K_ABORT && stb_cyc == wait_n + 1) begin
                    req_stb  = 1'b0;
                    req_cyc  = 1'b0;
                    released = 1'b1;
                    wb_ack_i = 1'b1;
                    wb_dat_i = sdat;
                end else if (kind != K_SILENT && kind != K_ABORT && stb_cyc == wait_n + 1) begin
                    wb_ack_i = (kind == K_ACK || kind == K_BOTH);
                    wb_err_i = (kind == K_ERR || kind == K_BOTH);
                    wb_dat_i = sdat;
                    if (kind == K_ERR) begin
                        m_bus = 1'b1;
                        if (!we) m_dat = ERRD;
                    end else if (!we) begin
                        m_dat = sdat;
                    end
                end else if (stb_cyc == int'(TO)) begin
                    m_to = 1'b1;
                    if (!we) m_dat = ERRD;
                end
            end

            if (acks > 0 && !released) begin
                if (rel_cnt == hold_n) begin
                    req_stb  = 1'b0;
                    req_cyc  = 1'b0;
                    released = 1'b1;
                end
                rel_cnt++;
            end
        end
        idle_inputs();

        check_val("bus_cycles", 32'(bus_starts), 32'd1);
        check_val("stb_len", 32'(stb_cyc), 32'(exp_stb));
        check_val("ack_pulses", 32'(acks), (kind == K_ABORT) ? 32'd0 : 32'd1);
        if (kind != K_ABORT)
            check_val("ack_latency", 32'(ack_at), 32'(last_stb + 1));
        check_val("req_dat_o", req_dat_o, m_dat);
        check_val("err_timeout", 32'(err_timeout), 32'(m_to));
        check_val("err_bus", 32'(err_bus), 32'(m_bus));
        check_val("bus_idle", 32'({wb_cyc_o, wb_stb_o, req_ack}), 32'd0);
    endtask

    initial begin
        idle_inputs();
        m_dat = '0;
        m_to  = 1'b0;
        m_bus = 1'b0;

        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_val("rst_req", 32'({req_ack, wb_cyc_o, wb_stb_o, wb_we_o, err_timeout, err_bus}), 32'd0);
        check_val("rst_dat_o", req_dat_o, 32'd0);
        check_val("rst_adr", wb_adr_o, 32'd0);
        check_val("rst_wdat", wb_dat_o, 32'd0);
        check_val("rst_sel", 32'(wb_sel_o), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Read with two wait states.
        run_txn(1'b0, 4'b0001, 10'h044, 32'h0, K_ACK, 2, 2, 32'hDEAD_BEEF, 1'b0);
        // Write, immediate ack, mux keeps strobing a while.
        run_txn(1'b1, 4'b1000, 10'h3FC, 32'hA5A5_A5A5, K_ACK, 0, 3, 32'h1234_5678, 1'b0);
        // Silent slave: watchdog ends the cycle.
        run_txn(1'b0, 4'b0001, 10'h010, 32'h0, K_SILENT, 0, 1, 32'h0, 1'b0);
        pulse_clear();
        // Bus error, then ack+err together.
        run_txn(1'b0, 4'b0010, 10'h020, 32'h0, K_ERR, 1, 0, 32'h5555_0000, 1'b0);
        pulse_clear();
        run_txn(1'b0, 4'b0100, 10'h024, 32'h0, K_BOTH, 0, 1, 32'hCAFE_F00D, 1'b0);
        // Response on the last allowed cycle beats the watchdog.
        run_txn(1'b0, 4'b0001, 10'h028, 32'h0, K_ACK, int'(TO) - 1, 0, 32'h0BAD_CAFE, 1'b0);
        // Abort in the 2nd bus cycle with a same-cycle ack, then a normal read.
        run_txn(1'b0, 4'b0001, 10'h030, 32'h0, K_ABORT, 1, 0, 32'h7777_7777, 1'b0);
        run_txn(1'b0, 4'b0001, 10'h034, 32'h0, K_ACK, 0, 0, 32'h1357_9BDF, 1'b0);

        // Reset while a read sits on the bus.
        @(negedge clock);
        req_cyc = 1'b1; req_stb = 1'b1; req_we = 1'b0; req_sel = 4'b0001; req_addr = 10'h044;
        @(negedge clock);
        check_val("pre_rst_stb", 32'(wb_stb_o), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("mid_rst_bus", 32'({wb_cyc_o, wb_stb_o, req_ack}), 32'd0);
        check_val("mid_rst_dat", req_dat_o, 32'd0);
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        m_dat = '0;
        m_to  = 1'b0;
        m_bus = 1'b0;
        run_txn(1'b0, 4'b0001, 10'h044, 32'h0, K_ACK, 2, 2, 32'hDEAD_BEEF, 1'b0);

        // Randomized mix, including random flag clears.
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          wn;
            logic [9:0]  a;
            logic [3:0]  s;
            kind = int'($urandom_range(0, 4));
            wn   = int'($urandom_range(0, TO - 1));
            a    = 10'($urandom_range(0, 255)) << 2;
            s    = 4'b0001 << $urandom_range(0, 3);
            run_txn(1'($urandom_range(0, 1)), s, a, $urandom, kind, wn,
                    int'($urandom_range(0, 3)), $urandom, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
